// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller.
// Captures one frame from the receiver, then streams it out or flushes it.
module uart_rx_ctrl #(
  parameter int CONFIG_WIDTH = 32,
  parameter int DEPTH        = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [2:0]                cfg_baud,
  input  logic                      cfg_odd,
  input  logic [2:0]                cfg_len,
  input  logic                      cfg_par_en,
  input  logic                      cfg_cont,
  output logic [CONFIG_WIDTH-1:0]   rx_conf,
  output logic [CONFIG_WIDTH/2-1:0] rx_enable,
  output logic [CONFIG_WIDTH/2-1:0] rx_clear,
  input  logic                      rx_dout_valid,
  input  logic [7:0]                rx_dout,
  input  logic                      rx_error,
  input  logic                      rx_done,
  output logic                      m_valid,
  output logic [7:0]                m_data,
  output logic                      m_last,
  input  logic                      m_ready,
  output logic                      frame_ok,
  output logic                      frame_err,
  output logic                      busy,
  output logic [15:0]               frame_cnt,
  output logic [15:0]               err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int HW = CONFIG_WIDTH / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RECV,
    S_CHECK,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [2:0]    r_baud;
  logic          r_odd;
  logic [2:0]    r_len;
  logic          r_par;
  logic          r_cont;

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_err;
  logic [7:0]    r_buf [DEPTH];

  logic [PW-1:0] w_n;
  logic [HW-1:0] w_mask;
  logic [HW-1:0] w_bit6;
  logic [2:0]    w_len_norm;
  logic          w_rlast;
  logic          w_wr;
  logic          w_unused_rx_done;

  assign w_unused_rx_done = rx_done;
  assign busy       = (r_state != S_IDLE);
  assign w_len_norm = (cfg_len > 3'd5) ? 3'd5 : cfg_len;
  assign w_rlast    = (r_rptr == w_n - PW'(1));

  always_comb begin
    w_n = PW'(32);
    case (r_len)
      3'd0:    w_n = PW'(1);
      3'd1:    w_n = PW'(2);
      3'd2:    w_n = PW'(3);
      3'd3:    w_n = PW'(8);
      3'd4:    w_n = PW'(16);
      default: w_n = PW'(32);
    endcase
  end

  always_comb begin
    w_mask         = '0;
    w_mask[r_len]  = 1'b1;
    w_mask[6]      = r_par;
    w_bit6         = '0;
    w_bit6[6]      = 1'b1;
    rx_conf        = '0;
    rx_conf[HW+:3] = r_baud;
    rx_conf[0]     = r_odd;
  end

  assign w_wr = (r_state == S_RECV) && rx_dout_valid &&
                (r_wptr != w_n) && !abort;

  always_comb begin
    w_next    = r_state;
    rx_enable = '0;
    rx_clear  = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_ARM;
      end
      S_ARM: begin
        rx_enable = w_mask;
        rx_clear  = w_mask;
        w_next    = S_RECV;
      end
      S_RECV: begin
        rx_enable = w_mask;
        if (r_wptr == w_n) w_next = S_CHECK;
      end
      S_CHECK: begin
        rx_enable = w_mask;
        w_next    = r_err ? S_FLUSH : S_DRAIN;
      end
      S_DRAIN: begin
        m_valid = 1'b1;
        m_data  = r_buf[r_rptr[AW-1:0]];
        m_last  = w_rlast;
        if (m_ready && w_rlast) begin
          frame_ok = 1'b1;
          w_next   = r_cont ? S_ARM : S_IDLE;
        end
      end
      S_FLUSH: begin
        rx_clear  = w_mask | w_bit6;
        frame_err = 1'b1;
        w_next    = r_cont ? S_ARM : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Abort wins over start and over a same-cycle final handshake.
    if (abort) begin
      w_next = S_IDLE;
      if (r_state != S_IDLE) begin
        rx_enable = '0;
        rx_clear  = w_mask;
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_odd     <= 1'b0;
      r_len     <= '0;
      r_par     <= 1'b0;
      r_cont    <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_err     <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start && !abort) begin
        r_baud <= cfg_baud;
        r_odd  <= cfg_odd;
        r_len  <= w_len_norm;
        r_par  <= cfg_par_en;
        r_cont <= cfg_cont;
      end
      if (r_state == S_ARM) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_err  <= 1'b0;
      end
      if (r_state == S_RECV && !abort && rx_error) r_err <= 1'b1;
      if (w_wr) r_wptr <= r_wptr + PW'(1);
      if (m_valid && m_ready) r_rptr <= r_rptr + PW'(1);
      if (frame_ok && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 16'd1;
      if (frame_err && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

  // Buffer contents need no reset: the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_wr) r_buf[r_wptr[AW-1:0]] <= rx_dout;
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl.
// Expected bytes go into a queue as they are sent and are popped on output.
module tb_uart_rx_ctrl;

  logic        clock = 1'b0;
  logic        reset, start, abort;
  logic [2:0]  cfg_baud, cfg_len;
  logic        cfg_odd, cfg_par_en, cfg_cont;
  logic [31:0] rx_conf;
  logic [15:0] rx_enable, rx_clear;
  logic        rx_dout_valid, rx_error, rx_done;
  logic [7:0]  rx_dout;
  logic        m_valid, m_last, m_ready;
  logic [7:0]  m_data;
  logic        frame_ok, frame_err, busy;
  logic [15:0] frame_cnt, err_cnt;

  always #5 clock = ~clock;

  uart_rx_ctrl #(.CONFIG_WIDTH(32), .DEPTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .cfg_baud(cfg_baud), .cfg_odd(cfg_odd), .cfg_len(cfg_len),
    .cfg_par_en(cfg_par_en), .cfg_cont(cfg_cont),
    .rx_conf(rx_conf), .rx_enable(rx_enable), .rx_clear(rx_clear),
    .rx_dout_valid(rx_dout_valid), .rx_dout(rx_dout),
    .rx_error(rx_error), .rx_done(rx_done),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .frame_ok(frame_ok), .frame_err(frame_err),
    .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  int ok_n = 0, er_n = 0, mv_n = 0, hs_n = 0;
  int clr_n = 0, clr6_n = 0, bl_n = 0;

  always @(negedge clock) begin
    if (frame_ok) ok_n++;
    if (frame_err) er_n++;
    if (m_valid) mv_n++;
    if (m_valid && m_ready) hs_n++;
    if (rx_clear != 16'h0) clr_n++;
    if (rx_clear[6]) clr6_n++;
    if (!busy) bl_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit e, input bit push);
    rx_dout_valid = 1'b1;
    rx_dout = b;
    rx_error = e;
    if (push) exp_q.push_back(b);
    tick();
    rx_dout_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  // Starts a frame from IDLE; returns in the first RECV cycle.
  task automatic begin_frame(input logic [2:0] len, input bit par,
                             input bit odd, input logic [2:0] baud,
                             input bit cont);
    int lsel;
    logic [15:0] m;
    lsel = (len > 3'd5) ? 5 : int'(len);
    m = 16'(1 << lsel) | (par ? 16'h0040 : 16'h0000);
    cfg_len = len; cfg_par_en = par; cfg_odd = odd;
    cfg_baud = baud; cfg_cont = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_enable", rx_enable, m);
    chk("arm_clear", rx_clear, m);
    cfg_len = ~len; cfg_par_en = ~par; cfg_odd = ~odd;
    cfg_baud = ~baud; cfg_cont = ~cont;
    rx_dout_valid = 1'b1;
    rx_dout = 8'hEE;
    tick();
    rx_dout_valid = 1'b0;
  endtask

  task automatic drain(input bit stall, input int bound);
    int n, vc;
    bit got, pv;
    logic [7:0] pd, e;
    got = 0; pv = 0; n = 0; vc = 0; pd = '0;
    while (!got && n < bound) begin
      @(posedge clock);
      #1;
      if (stall) begin
        if (m_valid) vc++;
        m_ready = (vc >= 3) ? ~m_ready : 1'b0;
      end else begin
        m_ready = 1'b1;
      end
      #1;
      n++;
      if (pv) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, pd);
      end
      pv = m_valid && !m_ready;
      pd = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", m_data, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("m_data", m_data, e);
          chk("m_last", m_last, exp_q.size() == 0);
        end
        if (frame_ok) got = 1;
      end
    end
    m_ready = 1'b1;
    chk("drain_done", got, 1);
  endtask

  initial begin
    int s0, s1, s2, s3, seen;
    reset = 1; start = 0; abort = 0;
    cfg_baud = 0; cfg_len = 0; cfg_odd = 0; cfg_par_en = 0; cfg_cont = 0;
    rx_dout_valid = 0; rx_dout = 0; rx_error = 0; rx_done = 0;
    m_ready = 1;
    tick(); tick();
    chk("rst_conf", rx_conf, 0);
    chk("rst_enable", rx_enable, 0);
    chk("rst_clear", rx_clear, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mlast", m_last, 0);
    chk("rst_ok", frame_ok, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_ecnt", err_cnt, 0);
    reset = 0;
    tick();

    s0 = ok_n;
    begin_frame(3'd2, 0, 0, 3'd7, 0);
    chk("conf_baud7", rx_conf, 32'h0007_0000);
    send_byte(8'h11, 0, 1);
    start = 1'b1;
    send_byte(8'h22, 0, 1);
    start = 1'b0;
    send_byte(8'h33, 0, 1);
    drain(0, 20);
    tick();
    chk("f1_ok_pulses", ok_n - s0, 1);
    chk("f1_fcnt", frame_cnt, 1);
    chk("f1_idle", busy, 0);
    chk("f1_conf_held", rx_conf, 32'h0007_0000);

    s0 = mv_n; s1 = er_n;
    begin_frame(3'd3, 1, 1, 3'd3, 0);
    chk("conf_odd", rx_conf, 32'h0003_0001);
    s2 = clr6_n;
    for (int i = 0; i < 8; i++)
      send_byte(8'($urandom_range(0, 255)), i == 1, 0);
    seen = 0;
    for (int k = 0; k < 10 && busy; k++) begin
      tick();
      if (frame_err) begin
        seen++;
        chk("flush_clear", rx_clear, 32'h0048);
      end
    end
    chk("flush_idle", busy, 0);
    tick();
    chk("flush_seen", seen, 1);
    chk("flush_pulses", er_n - s1, 1);
    chk("flush_ecnt", err_cnt, 1);
    chk("flush_fcnt", frame_cnt, 1);
    chk("flush_no_mvalid", mv_n - s0, 0);
    chk("flush_clr6", clr6_n - s2, 1);

    s0 = ok_n; s1 = hs_n;
    begin_frame(3'd0, 0, 0, 3'd0, 0);
    send_byte(8'hA5, 0, 1);
    drain(1, 20);
    tick();
    chk("stall_ok", ok_n - s0, 1);
    chk("stall_hs", hs_n - s1, 1);
    chk("stall_fcnt", frame_cnt, 2);

    s0 = ok_n; s1 = er_n;
    begin_frame(3'd4, 0, 0, 3'd5, 0);
    s2 = clr_n;
    for (int i = 0; i < 5; i++)
      send_byte(8'($urandom_range(0, 255)), 0, 0);
    abort = 1'b1;
    #1;
    chk("abort_clear", rx_clear, 32'h0010);
    tick();
    abort = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_enable", rx_enable, 0);
    tick();
    chk("abort_clr_pulses", clr_n - s2, 1);
    chk("abort_fcnt", frame_cnt, 2);
    chk("abort_ecnt", err_cnt, 1);
    chk("abort_no_ok", ok_n - s0, 0);
    chk("abort_no_err", er_n - s1, 0);
    begin_frame(3'd4, 0, 0, 3'd5, 0);
    for (int i = 0; i < 16; i++)
      send_byte(8'($urandom_range(0, 255)), 0, 1);
    drain(0, 40);
    tick();
    chk("fresh16_fcnt", frame_cnt, 3);

    begin_frame(3'd0, 0, 0, 3'd1, 1);
    s0 = bl_n;
    send_byte(8'h5A, 0, 1);
    drain(0, 20);
    tick();
    chk("cont_arm1_busy", busy, 1);
    chk("cont_arm1_clear", rx_clear, 1);
    tick();
    send_byte(8'hC3, 0, 1);
    drain(0, 20);
    tick();
    chk("cont_arm2_clear", rx_clear, 1);
    chk("cont_busy_held", bl_n - s0, 0);
    chk("cont_fcnt", frame_cnt, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("cont_abort_idle", busy, 0);
    chk("cont_abort_fcnt", frame_cnt, 5);

    s0 = ok_n;
    force dut.frame_cnt = 16'hFFFE;
    tick();
    release dut.frame_cnt;
    tick();
    chk("sat_preset", frame_cnt, 32'hFFFE);
    begin_frame(3'd0, 0, 0, 3'd2, 0);
    send_byte(8'h01, 0, 1);
    drain(0, 20);
    tick();
    chk("sat_first", frame_cnt, 32'hFFFF);
    begin_frame(3'd7, 0, 0, 3'd2, 0);
    for (int i = 0; i < 32; i++)
      send_byte(8'($urandom_range(0, 255)), 0, 1);
    drain(0, 100);
    tick();
    chk("sat_second", frame_cnt, 32'hFFFF);
    chk("sat_ok_pulses", ok_n - s0, 2);

    begin_frame(3'd1, 0, 0, 3'd4, 0);
    send_byte(8'h77, 0, 0);
    s0 = ok_n; s1 = er_n; s3 = mv_n;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_fcnt", frame_cnt, 0);
    chk("midrst_ecnt", err_cnt, 0);
    chk("midrst_conf", rx_conf, 0);
    repeat (4) tick();
    chk("midrst_no_ok", ok_n - s0, 0);
    chk("midrst_no_err", er_n - s1, 0);
    chk("midrst_no_mvalid", mv_n - s3, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CONFIG_WIDTH, default 32, giving the receiver config width.
REQ-002 SHALL have parameter DEPTH, default 32, giving the frame buffer depth in bytes, equal to the maximum frame length.
REQ-003 SHALL have port clock, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, pulse that begins a frame capture when IDLE.
REQ-006 SHALL have port abort, input, 1, cancels the current operation from any state.
REQ-007 SHALL have port cfg_baud, input, 3, baud select, 0=1200 to 7=115200.
REQ-008 SHALL have port cfg_odd, input, 1, odd parity when 1, even parity when 0.
REQ-009 SHALL have port cfg_len, input, 3, frame length select: 0/1/2/3/4/5 = 1/2/3/8/16/32 bytes; 6 and 7 treated as 5.
REQ-010 SHALL have port cfg_par_en, input, 1, enables parity checking.
REQ-011 SHALL have port cfg_cont, input, 1, continuous mode: re-arm after each frame.
REQ-012 SHALL have port rx_conf, output, CONFIG_WIDTH, receiver config.
REQ-013 SHALL have ports rx_enable and rx_clear, output, CONFIG_WIDTH/2 each, receiver status enable and clear.
REQ-014 SHALL have ports rx_dout_valid (1), rx_dout (8), rx_error (1) and rx_done (1), all inputs, from the receiver.
REQ-015 SHALL have ports m_valid (out, 1), m_data (out, 8), m_last (out, 1) and m_ready (in, 1), the byte output stream.
REQ-016 SHALL have ports frame_ok (out, 1) and frame_err (out, 1), single-cycle completion pulses.
REQ-017 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-018 SHALL have ports frame_cnt and err_cnt, output, 16 each, saturating counters.

Function
REQ-019 SHALL implement states IDLE, ARM, RECV, CHECK, DRAIN and FLUSH.
REQ-020 SHALL, on start in IDLE, latch all cfg_* into shadow registers and enter ARM next cycle; cfg changes after that point SHALL have no effect until the next latch.
REQ-021 SHALL drive rx_conf as: [31:16] = zero-extended shadow baud, [0] = shadow odd, all other bits 0.
REQ-022 SHALL hold rx_enable and rx_clear at 0 in IDLE.
REQ-023 SHALL set rx_enable, in ARM/RECV/CHECK, to the one-hot length bit (len select 0..5 maps to bit 0..5) OR'd with bit6 = shadow par_en.
REQ-024 SHALL stay in ARM exactly 1 cycle with rx_clear = rx_enable, reset wptr and the sticky error, then enter RECV.
REQ-025 SHALL ignore rx_dout_valid in ARM.
REQ-026 SHALL, in RECV, write each rx_dout_valid byte to buf[wptr], increment wptr, and set the sticky error whenever rx_error=1.
REQ-027 SHALL enter CHECK on the cycle after wptr reaches N, the shadow frame length.
REQ-028 SHALL, in CHECK (1 cycle), enter FLUSH if the sticky error is set, else DRAIN.
REQ-029 SHALL, in DRAIN, present buf[rptr] with m_valid=1 starting at rptr=0, advance rptr on each m_valid&m_ready, and hold m_data stable while m_ready=0.
REQ-030 SHALL assert m_last with the byte at rptr=N-1.
REQ-031 SHALL, on the final handshake, pulse frame_ok and increment frame_cnt.
REQ-032 SHALL, in FLUSH (1 cycle), drive rx_clear = rx_enable | bit6, pulse frame_err, increment err_cnt, and discard the buffer.
REQ-033 SHALL, after DRAIN or FLUSH completes, enter ARM if shadow cont=1, else IDLE.
REQ-034 SHALL, on abort in any non-IDLE state, enter IDLE next cycle, pulse rx_clear = rx_enable for that cycle, drop m_valid, leave counters unchanged, and produce no frame_ok/frame_err.
REQ-035 SHALL give abort priority over start and over a simultaneous final handshake.
REQ-036 SHALL stop frame_cnt and err_cnt at 16'hFFFF without wrapping.
REQ-037 SHALL ignore rx_done functionally.
REQ-038 SHALL ignore start outside IDLE.

Reset
REQ-039 SHALL, on reset, set state=IDLE, wptr=rptr=0, sticky error=0, all shadow config=0, counters=0, and all outputs 0 (rx_conf=0, rx_enable=0, rx_clear=0, m_valid=0, m_last=0, frame_ok=0, frame_err=0, busy=0).
REQ-040 SHALL make reset mid-frame discard all buffered data with no pulses.

Verification
REQ-041 SHALL verify: cfg_len=2, cfg_baud=7, start, 3 bytes 0x11/0x22/0x33, m_ready=1 -> rx_conf=0x00070000; m_data 11,22,33 with m_last on 33; one frame_ok; frame_cnt=1.
REQ-042 SHALL verify: cfg_par_en=1, rx_error pulse on byte 2 of 8 -> FLUSH; frame_err pulse; err_cnt=1; m_valid never asserted; rx_clear[6]=1 for one cycle.
REQ-043 SHALL verify: cfg_len=0, m_ready toggled 0/1 -> m_data held stable while m_ready=0; exactly one byte delivered with m_last=1.
REQ-044 SHALL verify: abort during RECV after 5 of 16 bytes -> IDLE next cycle; one rx_clear pulse; counters unchanged; later start accepts a fresh 16-byte frame.
REQ-045 SHALL verify: cfg_cont=1, two back-to-back 1-byte frames -> ARM re-entered after each DRAIN; frame_cnt=2; busy stays 1.
REQ-046 SHALL verify: frame_cnt forced to 0xFFFE, two good frames -> frame_cnt=0xFFFF.
